// File: rtl/axis_pixel_packer_pkg.sv
// Shared pixel-stream definitions: image geometry, lane layout and the packer
// control states, plus the byte-enable helper used when a word is closed.
package axis_pixel_packer_pkg;

    localparam int PIXEL_W      = 8;
    localparam int LANES        = 4;
    localparam int IMAGE_WIDTH  = 512;
    localparam int IMAGE_HEIGHT = 512;
    localparam int FRAME_PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;

    // Wide enough for the largest legal frame index (2^24 - 1).
    localparam int PIX_CNT_W  = 24;
    localparam int LANE_CNT_W = 2;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } pack_state_e;

    // Byte-enable mask covering lanes 0 .. last_lane.
    function automatic logic [LANES-1:0] keep_mask(input logic [LANE_CNT_W-1:0] last_lane);
        logic [LANES-1:0] mask;
        case (last_lane)
            2'd0:    mask = 4'b0001;
            2'd1:    mask = 4'b0011;
            2'd2:    mask = 4'b0111;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/axis_pixel_packer.sv
// Packs a stream of 8-bit pixels into 32-bit little-endian words with byte
// keep, end-of-frame marking and a frame-done pulse after the last word drains.
module axis_pixel_packer
    import axis_pixel_packer_pkg::*;
#(
    parameter int FRAME_PIXELS = axis_pixel_packer_pkg::FRAME_PIXELS,
    parameter int LANES        = axis_pixel_packer_pkg::LANES
) (
    input  logic                       axis_clk,
    input  logic                       axis_reset,
    input  logic                       i_s_data_valid,
    input  logic [PIXEL_W-1:0]         i_s_data,
    output logic                       o_s_ready,
    output logic                       o_m_data_valid,
    output logic [PIXEL_W*LANES-1:0]   o_m_data,
    output logic [LANES-1:0]           o_m_keep,
    output logic                       o_m_last,
    input  logic                       i_m_ready,
    output logic                       o_frame_done
);

    localparam int                    WORD_W    = PIXEL_W * LANES;
    localparam logic [PIX_CNT_W-1:0]  LAST_PIX  = PIX_CNT_W'(FRAME_PIXELS - 1);
    localparam logic [LANE_CNT_W-1:0] LAST_LANE = LANE_CNT_W'(LANES - 1);

    pack_state_e            state_r, state_s;
    logic [LANE_CNT_W-1:0]  lane_cnt_r, lane_cnt_s;
    logic [PIX_CNT_W-1:0]   pix_cnt_r, pix_cnt_s;
    logic [WORD_W-1:0]      acc_r, acc_s, word_s;
    logic [WORD_W-1:0]      m_data_r;
    logic [LANES-1:0]       m_keep_r;
    logic                   m_last_r;
    logic                   frame_done_r;
    logic                   accept_s, drain_s, last_pix_s, complete_s;

    assign o_m_data_valid = (state_r == ST_HOLD);
    assign o_s_ready      = !o_m_data_valid || i_m_ready;
    assign o_m_data       = m_data_r;
    assign o_m_keep       = m_keep_r;
    assign o_m_last       = m_last_r;
    assign o_frame_done   = frame_done_r;

    assign accept_s   = i_s_data_valid && o_s_ready;
    assign drain_s    = o_m_data_valid && i_m_ready;
    assign last_pix_s = (pix_cnt_r == LAST_PIX);
    assign complete_s = accept_s && ((lane_cnt_r == LAST_LANE) || last_pix_s);

    // Accumulator merge and counter advance for an accepted pixel.
    always_comb begin
        acc_s      = acc_r;
        lane_cnt_s = lane_cnt_r;
        pix_cnt_s  = pix_cnt_r;
        word_s     = acc_r;
        for (int k = 0; k < LANES; k++) begin
            if (lane_cnt_r == LANE_CNT_W'(k)) begin
                word_s[k*PIXEL_W +: PIXEL_W] = i_s_data;
            end else begin
                word_s[k*PIXEL_W +: PIXEL_W] = acc_r[k*PIXEL_W +: PIXEL_W];
            end
        end
        if (accept_s) begin
            // Clearing on completion keeps unfilled lanes of the next word at zero.
            if (complete_s) begin
                acc_s      = {WORD_W{1'b0}};
                lane_cnt_s = {LANE_CNT_W{1'b0}};
            end else begin
                acc_s      = word_s;
                lane_cnt_s = lane_cnt_r + 2'd1;
            end
            if (last_pix_s) begin
                pix_cnt_s = {PIX_CNT_W{1'b0}};
            end else begin
                pix_cnt_s = pix_cnt_r + 24'd1;
            end
        end else begin
            acc_s      = acc_r;
            lane_cnt_s = lane_cnt_r;
            pix_cnt_s  = pix_cnt_r;
        end
    end

    // Output-register occupancy: FILL when empty, HOLD while a word is offered.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_FILL: begin
                if (complete_s) begin
                    state_s = ST_HOLD;
                end else begin
                    state_s = ST_FILL;
                end
            end
            ST_HOLD: begin
                if (drain_s && !complete_s) begin
                    state_s = ST_FILL;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: state_s = ST_FILL;
        endcase
    end

    // Control state and packing counters.
    always_ff @(posedge axis_clk or posedge axis_reset) begin
        if (axis_reset) begin
            state_r    <= ST_FILL;
            lane_cnt_r <= {LANE_CNT_W{1'b0}};
            pix_cnt_r  <= {PIX_CNT_W{1'b0}};
            acc_r      <= {WORD_W{1'b0}};
        end else begin
            state_r    <= state_s;
            lane_cnt_r <= lane_cnt_s;
            pix_cnt_r  <= pix_cnt_s;
            acc_r      <= acc_s;
        end
    end

    // Output word register; only a completing pixel may overwrite it.
    always_ff @(posedge axis_clk or posedge axis_reset) begin
        if (axis_reset) begin
            m_data_r     <= {WORD_W{1'b0}};
            m_keep_r     <= {LANES{1'b0}};
            m_last_r     <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            if (complete_s) begin
                m_data_r <= word_s;
                m_keep_r <= keep_mask(lane_cnt_r);
                m_last_r <= last_pix_s;
            end else begin
                m_data_r <= m_data_r;
                m_keep_r <= m_keep_r;
                m_last_r <= m_last_r;
            end
            frame_done_r <= drain_s && m_last_r;
        end
    end

endmodule

// File: tb/tb_axis_pixel_packer.sv
// Directed bench for axis_pixel_packer: an 8-pixel-frame instance and a
// 6-pixel-frame instance (short final word) driven from one linear sequence.
module tb_axis_pixel_packer;

    logic        clk;
    logic        rst;

    logic        a_valid, a_mready, a_sready, a_mvalid, a_last, a_done;
    logic [7:0]  a_data;
    logic [31:0] a_word;
    logic [3:0]  a_keep;

    logic        b_valid, b_mready, b_sready, b_mvalid, b_last, b_done;
    logic [7:0]  b_data;
    logic [31:0] b_word;
    logic [3:0]  b_keep;

    int errors = 0;
    int checks = 0;

    axis_pixel_packer #(.FRAME_PIXELS(8), .LANES(4)) dut_a (
        .axis_clk       (clk),
        .axis_reset     (rst),
        .i_s_data_valid (a_valid),
        .i_s_data       (a_data),
        .o_s_ready      (a_sready),
        .o_m_data_valid (a_mvalid),
        .o_m_data       (a_word),
        .o_m_keep       (a_keep),
        .o_m_last       (a_last),
        .i_m_ready      (a_mready),
        .o_frame_done   (a_done)
    );

    axis_pixel_packer #(.FRAME_PIXELS(6), .LANES(4)) dut_b (
        .axis_clk       (clk),
        .axis_reset     (rst),
        .i_s_data_valid (b_valid),
        .i_s_data       (b_data),
        .o_s_ready      (b_sready),
        .o_m_data_valid (b_mvalid),
        .o_m_data       (b_word),
        .o_m_keep       (b_keep),
        .o_m_last       (b_last),
        .i_m_ready      (b_mready),
        .o_frame_done   (b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [7:0] d);
        a_valid = 1'b1;
        a_data  = d;
        tick();
    endtask

    task automatic push_b(input logic [7:0] d);
        b_valid = 1'b1;
        b_data  = d;
        tick();
    endtask

    // Expected word on instance A: valid, data, keep, last.
    task automatic chk_a_word(input string tag, input logic [31:0] w, input logic [3:0] k, input logic l);
        chk({tag, "_valid"}, 64'(a_mvalid), 64'd1);
        chk({tag, "_data"},  64'(a_word),   64'(w));
        chk({tag, "_keep"},  64'(a_keep),   64'(k));
        chk({tag, "_last"},  64'(a_last),   64'(l));
    endtask

    // Standard 01..08 frame on instance A with downstream always ready.
    task automatic frame_a_basic(input string tag);
        push_a(8'h01); push_a(8'h02); push_a(8'h03);
        chk({tag, "_empty_p3"}, 64'(a_mvalid), 64'd0);
        push_a(8'h04);
        chk_a_word({tag, "_w1"}, 32'h04030201, 4'hF, 1'b0);
        push_a(8'h05);
        chk({tag, "_drained_w1"}, 64'(a_mvalid), 64'd0);
        chk({tag, "_no_done_w1"}, 64'(a_done), 64'd0);
        push_a(8'h06); push_a(8'h07); push_a(8'h08);
        chk_a_word({tag, "_w2"}, 32'h08070605, 4'hF, 1'b1);
        a_valid = 1'b0;
        tick();
        chk({tag, "_done_pulse"}, 64'(a_done), 64'd1);
        chk({tag, "_idle_valid"}, 64'(a_mvalid), 64'd0);
        tick();
        chk({tag, "_done_clear"}, 64'(a_done), 64'd0);
    endtask

    initial begin
        rst      = 1'b1;
        a_valid  = 1'b0; a_data = 8'h00; a_mready = 1'b1;
        b_valid  = 1'b0; b_data = 8'h00; b_mready = 1'b1;

        // Reset state
        tick();
        chk("rst_valid", 64'(a_mvalid), 64'd0);
        chk("rst_data",  64'(a_word),   64'd0);
        chk("rst_keep",  64'(a_keep),   64'd0);
        chk("rst_last",  64'(a_last),   64'd0);
        chk("rst_done",  64'(a_done),   64'd0);
        chk("rst_ready", 64'(a_sready), 64'd1);
        rst = 1'b0;
        tick();

        // Eight-pixel frame, two full words
        frame_a_basic("f8");

        // Six-pixel frame, short final word
        push_b(8'h11); push_b(8'h12); push_b(8'h13); push_b(8'h14);
        chk("f6_w1_valid", 64'(b_mvalid), 64'd1);
        chk("f6_w1_data",  64'(b_word),   64'h14131211);
        chk("f6_w1_keep",  64'(b_keep),   64'hF);
        chk("f6_w1_last",  64'(b_last),   64'd0);
        push_b(8'h15);
        push_b(8'h16);
        chk("f6_w2_valid", 64'(b_mvalid), 64'd1);
        chk("f6_w2_data",  64'(b_word),   64'h00001615);
        chk("f6_w2_keep",  64'(b_keep),   64'h3);
        chk("f6_w2_last",  64'(b_last),   64'd1);
        b_valid = 1'b0;
        tick();
        chk("f6_done", 64'(b_done), 64'd1);
        tick();
        chk("f6_done_clear", 64'(b_done), 64'd0);

        // Downstream stall with a word pending
        a_mready = 1'b0;
        push_a(8'h01); push_a(8'h02); push_a(8'h03); push_a(8'h04);
        a_valid = 1'b1;
        a_data  = 8'h05;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_sready", 64'(a_sready), 64'd0);
            chk("stall_data",   64'(a_word),   64'h04030201);
            chk("stall_valid",  64'(a_mvalid), 64'd1);
        end
        a_mready = 1'b1;
        #1;
        chk("release_sready", 64'(a_sready), 64'd1);
        tick();
        chk("release_drained", 64'(a_mvalid), 64'd0);
        push_a(8'h06); push_a(8'h07); push_a(8'h08);
        chk_a_word("stall_w2", 32'h08070605, 4'hF, 1'b1);
        a_valid = 1'b0;
        tick();
        chk("stall_done", 64'(a_done), 64'd1);
        tick();

        // Two frames back-to-back with continuous valid
        push_a(8'h01); push_a(8'h02); push_a(8'h03); push_a(8'h04);
        chk_a_word("b2b_w1", 32'h04030201, 4'hF, 1'b0);
        push_a(8'h05); push_a(8'h06); push_a(8'h07); push_a(8'h08);
        chk_a_word("b2b_w2", 32'h08070605, 4'hF, 1'b1);
        push_a(8'h21);
        chk("b2b_done1", 64'(a_done), 64'd1);
        push_a(8'h22);
        chk("b2b_done1_clear", 64'(a_done), 64'd0);
        push_a(8'h23); push_a(8'h24);
        chk_a_word("b2b_w3", 32'h24232221, 4'hF, 1'b0);
        push_a(8'h25); push_a(8'h26); push_a(8'h27); push_a(8'h28);
        chk_a_word("b2b_w4", 32'h28272625, 4'hF, 1'b1);
        a_valid = 1'b0;
        tick();
        chk("b2b_done2", 64'(a_done), 64'd1);
        tick();

        // Reset mid-frame discards the partial word
        push_a(8'h01); push_a(8'h02); push_a(8'h03);
        a_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid", 64'(a_mvalid), 64'd0);
        chk("midrst_data",  64'(a_word),   64'd0);
        chk("midrst_done",  64'(a_done),   64'd0);
        tick();
        rst = 1'b0;
        tick();
        frame_a_basic("restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
